// File: rtl/reaction_game_pkg.sv
// reaction_game_pkg: shared state encoding, timing defaults and window helper for the reaction game
package reaction_game_pkg;
  typedef enum logic [2:0] {IDLE, ARM, TARGET, SCORE, GAME_OVER} state_t;
  localparam int ARM_DELAY_MS = 10;
  localparam int BASE_WINDOW_MS = 1000;
  function automatic int window_ms(int lvl, int base, int step, int floor_ms);
    return (lvl * step >= base - floor_ms) ? floor_ms : base - lvl * step;
  endfunction
endpackage

// File: rtl/lane_toggle_detect.sv
// lane_toggle_detect: flags every lane whose switch changed since the previous cycle
module lane_toggle_detect #(
  parameter int N_LANES = 18
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_LANES-1:0] switches,
  output logic [N_LANES-1:0] toggle
);
  logic [N_LANES-1:0] prev;
  // remember last cycle's switch levels
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) prev <= '0;
    else prev <= switches;
  assign toggle = switches ^ prev;
endmodule

// File: rtl/multi_lane_reaction_game_fsm.sv
// multi_lane_reaction_game_fsm: N-lane reaction game controller; REACTION_GAME_PENALTY_EN makes wrong-lane toggles cost a point
module multi_lane_reaction_game_fsm
  import reaction_game_pkg::*;
#(
  parameter int N_LANES        = 18,
  parameter int SCORE_W        = 7,
  parameter int LEVEL_W        = 4,
  parameter int MAX_LEVEL      = 9,
  parameter int HITS_PER_LEVEL = 5,
  parameter int ARM_DELAY_MS   = reaction_game_pkg::ARM_DELAY_MS,
  parameter int BASE_WINDOW_MS = reaction_game_pkg::BASE_WINDOW_MS,
  parameter int WINDOW_STEP_MS = 100,
  parameter int MIN_WINDOW_MS  = 200,
  parameter int TIMER_W        = 11
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       button_edge,
  input  logic [N_LANES-1:0]         switches,
  input  logic [$clog2(N_LANES)-1:0] random_value,
  input  logic [TIMER_W-1:0]         timer_value,
  input  logic [5:0]                 game_timer_value,
  output logic                       reset,
  output logic                       up,
  output logic                       enable,
  output logic [TIMER_W-1:0]         start_value,
  output logic                       game_reset,
  output logic                       game_timer_enable,
  output logic [N_LANES-1:0]         leds,
  output logic [SCORE_W-1:0]         user_score,
  output logic [LEVEL_W-1:0]         level
);
  localparam int LANE_W = $clog2(N_LANES);
  localparam int HIT_W = $clog2(HITS_PER_LEVEL + 1);
  state_t state, state_n;
  logic [LANE_W-1:0] lane, lane_n;
  logic [HIT_W-1:0] hits, hits_n;
  logic hit_q, hit_q_n;
  logic [SCORE_W-1:0] score_n;
  logic [LEVEL_W-1:0] level_n;
  logic reset_d, enable_d, game_reset_d;
  logic [TIMER_W-1:0] start_d;
  logic [N_LANES-1:0] leds_d, toggle;
  logic round_exp, game_over, hit, penalty, apply_hit, level_up;

  lane_toggle_detect #(.N_LANES(N_LANES)) u_toggle (
    .clk      (clk),
    .reset_n  (reset_n),
    .switches (switches),
    .toggle   (toggle)
  );

  assign up = 1'b0;
  // a timer value seen while a load is pending is stale, so it never counts as expiry
  assign round_exp = timer_value == '0 && !reset;
  assign game_over = game_timer_value == '0 && (state == ARM || state == TARGET || state == SCORE);
  assign hit = state == TARGET && toggle[lane];
`ifdef REACTION_GAME_PENALTY_EN
  assign penalty = state == TARGET && !hit && |(toggle & ~({{(N_LANES-1){1'b0}}, 1'b1} << lane));
`else
  assign penalty = 1'b0;
`endif
  // a hit is credited in SCORE, or immediately when the game ends in the same cycle
  assign apply_hit = (state == SCORE && hit_q) || (hit && game_over);
  assign level_up = apply_hit && hits == HIT_W'(HITS_PER_LEVEL - 1);

  // next state, score bookkeeping and next registered outputs
  always_comb begin
    state_n = state;
    lane_n = lane;
    hits_n = hits;
    hit_q_n = 1'b0;
    score_n = user_score;
    level_n = level;
    case (state)
      IDLE: if (button_edge) begin
        state_n = ARM;
        score_n = '0;
        level_n = '0;
        hits_n = '0;
      end
      ARM: if (game_over) state_n = GAME_OVER;
      else if (round_exp) begin
        state_n = TARGET;
        lane_n = random_value >= N_LANES ? LANE_W'(random_value - N_LANES) : random_value;
      end
      TARGET: if (game_over) state_n = GAME_OVER;
      else if (hit || round_exp) begin
        state_n = SCORE;
        hit_q_n = hit;
      end
      SCORE: state_n = game_over ? GAME_OVER : ARM;
      GAME_OVER: if (button_edge) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (apply_hit) begin
      score_n = &user_score ? user_score : user_score + 1'b1;
      hits_n = level_up ? '0 : hits + 1'b1;
      if (level_up && level != LEVEL_W'(MAX_LEVEL)) level_n = level + 1'b1;
    end else if (penalty && user_score != '0) score_n = user_score - 1'b1;
    leds_d = state_n == GAME_OVER ? '1 : state_n == TARGET ? {{(N_LANES-1){1'b0}}, 1'b1} << lane_n : '0;
    enable_d = state_n == ARM || state_n == TARGET || state_n == SCORE;
    game_reset_d = state_n == IDLE;
    reset_d = state_n == IDLE || state_n == SCORE || (state == ARM && state_n == TARGET);
    start_d = state_n == TARGET ? TIMER_W'(window_ms(int'(level), BASE_WINDOW_MS, WINDOW_STEP_MS, MIN_WINDOW_MS))
                                : TIMER_W'(ARM_DELAY_MS);
  end

  // state and all outputs registered
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      lane <= '0;
      hits <= '0;
      hit_q <= 1'b0;
      user_score <= '0;
      level <= '0;
      reset <= 1'b1;
      enable <= 1'b0;
      start_value <= TIMER_W'(ARM_DELAY_MS);
      game_reset <= 1'b1;
      game_timer_enable <= 1'b0;
      leds <= '0;
    end else begin
      state <= state_n;
      lane <= lane_n;
      hits <= hits_n;
      hit_q <= hit_q_n;
      user_score <= score_n;
      level <= level_n;
      reset <= reset_d;
      enable <= enable_d;
      start_value <= start_d;
      game_reset <= game_reset_d;
      game_timer_enable <= enable_d;
      leds <= leds_d;
    end
endmodule
